// File: rtl/serial_receiver.sv
// serial_receiver: reassembles a 32-bit word from 32/LENGTH chunks (MS chunk first), held until rxAck.
// Latency: 32/LENGTH+1 cycles from startRx with din valid every cycle; gaps stretch the frame 1:1.
// Backpressure: the held word blocks new frames until rxAck; chunks/starts arriving while held set sticky overrun.
// Optional feature: define SERIAL_RX_TIMEOUT_EN to abort a frame after TIMEOUT idle cycles (timeoutErr pulse).

module serial_receiver #(
   parameter int LENGTH  = 4,   // chunk width; must divide 32 (1, 2, 4, 8, 16, 32)
   parameter int TIMEOUT = 16   // idle cycles tolerated mid-frame, only with SERIAL_RX_TIMEOUT_EN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LENGTH-1:0] din,
   input  logic              dinValid,
   input  logic              startRx,
   input  logic              rxAck,
   output logic [31:0]       dout,
   output logic              rxDone,
   output logic              rxBusy,
   output logic              overrun,
   output logic              timeoutErr
);

   // Number of chunks per word; the counter is 6 bits so LENGTH=1 (32 chunks) fits.
   localparam int         CHUNKS     = 32 / LENGTH;
   localparam logic [5:0] COUNT_LOAD = 6'(CHUNKS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] shift_reg;
   logic [31:0] shift_next;
   logic [31:0] shift_in;      // shift register with the current chunk appended at the LSB end
   logic [5:0]  count;
   logic [5:0]  count_next;
   logic [31:0] dout_next;
   logic        overrun_next;
   logic        timeout_hit;   // abort request from the idle watchdog

   // A single chunk fills the whole word, so there is nothing to shift in that case.
   generate
      if (LENGTH == 32) begin : g_single_chunk
         assign shift_in = 32'(din);
      end else begin : g_multi_chunk
         assign shift_in = {shift_reg[31-LENGTH:0], din};
      end
   endgenerate

`ifdef SERIAL_RX_TIMEOUT_EN
   // Width holds TIMEOUT itself so the counter never wraps before the compare fires.
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_cnt;

   // The abort fires on the edge that would complete the TIMEOUT-th consecutive idle cycle;
   // a restart or an accepted chunk in the same cycle takes precedence.
   assign timeout_hit = (state == RECV) && !startRx && !dinValid &&
                        (idle_cnt == IDLE_W'(TIMEOUT - 1));

   // Idle watchdog: counts dinValid-low cycles in RECV, cleared outside RECV and by any activity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if ((state != RECV) || startRx || dinValid) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // One-cycle abort pulse, aligned with the FSM returning to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeoutErr <= 1'b0;
      end else begin
         timeoutErr <= timeout_hit;
      end
   end
`else
   // Without the watchdog RECV waits indefinitely for the remaining chunks.
   assign timeout_hit = 1'b0;
   assign timeoutErr  = 1'b0;
`endif

   // State, shift register, chunk counter, output word and sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         count     <= '0;
         dout      <= '0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         count     <= count_next;
         dout      <= dout_next;
         overrun   <= overrun_next;
      end
   end

   // Next-state logic; startRx always wins inside RECV so a restart never captures its own-cycle din.
   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      count_next   = count;
      dout_next    = dout;
      overrun_next = overrun;

      case (state)
         IDLE: begin
            if (startRx) begin
               state_next = RECV;
               count_next = COUNT_LOAD;
               shift_next = '0;
            end
         end

         RECV: begin
            if (startRx) begin
               // Restart: the partial word is dropped silently.
               count_next = COUNT_LOAD;
               shift_next = '0;
            end else if (dinValid) begin
               shift_next = shift_in;
               count_next = count - 6'd1;
               if (count == 6'd1) begin
                  dout_next  = shift_in;
                  state_next = HOLD;
               end
            end else if (timeout_hit) begin
               // Abandon the frame; dout keeps the last completed word.
               state_next = IDLE;
               shift_next = '0;
               count_next = '0;
            end
         end

         HOLD: begin
            if (rxAck) begin
               if (startRx) begin
                  state_next = RECV;
                  count_next = COUNT_LOAD;
                  shift_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end else if (startRx || dinValid) begin
               // Sender did not wait for the consumer; the held word is preserved.
               overrun_next = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status flags are pure state decodes, so they can never be high together.
   assign rxBusy = (state == RECV);
   assign rxDone = (state == HOLD);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: one LENGTH=4 and one LENGTH=8 instance.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Timeout expectations follow whether SERIAL_RX_TIMEOUT_EN is defined.

module tb_serial_receiver;

   logic        clk;
   logic        reset;

   logic [3:0]  din4;
   logic        dv4, st4, ack4;
   logic [31:0] dout4;
   logic        done4, busy4, ovr4, to4;

   logic [7:0]  din8;
   logic        dv8, st8, ack8;
   logic [31:0] dout8;
   logic        done8, busy8, ovr8, to8;

   int chk_cnt;
   int pass_cnt;

   serial_receiver #(.LENGTH(4), .TIMEOUT(16)) u_dut4 (
      .clk(clk), .reset(reset), .din(din4), .dinValid(dv4), .startRx(st4), .rxAck(ack4),
      .dout(dout4), .rxDone(done4), .rxBusy(busy4), .overrun(ovr4), .timeoutErr(to4)
   );

   serial_receiver #(.LENGTH(8), .TIMEOUT(16)) u_dut8 (
      .clk(clk), .reset(reset), .din(din8), .dinValid(dv8), .startRx(st8), .rxAck(ack8),
      .dout(dout8), .rxDone(done8), .rxBusy(busy8), .overrun(ovr8), .timeoutErr(to8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send a full word to the LENGTH=4 instance, one nibble per cycle, MS nibble first.
   task automatic send4(input logic [31:0] w);
      for (int i = 0; i < 8; i++) begin
         din4 = w[31-4*i -: 4];
         dv4  = 1'b1;
         step();
      end
      dv4  = 1'b0;
      din4 = 4'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      chk_cnt++;
      if ({dout4, done4, busy4, ovr4, to4} !== 36'h0)
         $display("FAIL reset_dut4: got dout=%h done=%b busy=%b ovr=%b to=%b required all 0",
                  dout4, done4, busy4, ovr4, to4);
      else pass_cnt++;
      chk_cnt++;
      if ({dout8, done8, busy8, ovr8, to8} !== 36'h0)
         $display("FAIL reset_dut8: got dout=%h done=%b busy=%b ovr=%b to=%b required all 0",
                  dout8, done8, busy8, ovr8, to8);
      else pass_cnt++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_deadbeef();
      logic [31:0] w;
      w = 32'hDEADBEEF;
      // din offered with startRx must be ignored
      st4 = 1'b1; dv4 = 1'b1; din4 = 4'hF;
      step();
      st4 = 1'b0;
      chk_cnt++;
      if ({done4, busy4} !== 2'b01)
         $display("FAIL start_busy: got done=%b busy=%b required done=0 busy=1", done4, busy4);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         din4 = w[31-4*i -: 4];
         dv4  = 1'b1;
         step();
         if (i == 6) begin
            chk_cnt++;
            if ({done4, busy4} !== 2'b01)
               $display("FAIL seven_chunks: got done=%b busy=%b required done=0 busy=1", done4, busy4);
            else pass_cnt++;
         end
      end
      dv4 = 1'b0;
      chk_cnt++;
      if ({done4, busy4} !== 2'b10)
         $display("FAIL deadbeef_done: got done=%b busy=%b required done=1 busy=0", done4, busy4);
      else pass_cnt++;
      chk_cnt++;
      if (dout4 !== 32'hDEADBEEF)
         $display("FAIL deadbeef_dout: got %h required %h", dout4, 32'hDEADBEEF);
      else pass_cnt++;
      ack4 = 1'b1;
      step();
      ack4 = 1'b0;
      chk_cnt++;
      if ({done4, busy4} !== 2'b00)
         $display("FAIL ack_idle: got done=%b busy=%b required done=0 busy=0", done4, busy4);
      else pass_cnt++;
      chk_cnt++;
      if (dout4 !== 32'hDEADBEEF)
         $display("FAIL ack_dout_kept: got %h required %h", dout4, 32'hDEADBEEF);
      else pass_cnt++;
   endtask

   task automatic test_restart();
      st4 = 1'b1;
      step();
      st4 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         din4 = 4'(i);
         dv4  = 1'b1;
         step();
      end
      // restart with a valid chunk in the same cycle; that chunk must be dropped
      st4 = 1'b1; dv4 = 1'b1; din4 = 4'h9;
      step();
      st4 = 1'b0;
      send4(32'hCAFEF00D);
      chk_cnt++;
      if (dout4 !== 32'hCAFEF00D)
         $display("FAIL restart_dout: got %h required %h", dout4, 32'hCAFEF00D);
      else pass_cnt++;
      chk_cnt++;
      if ({done4, ovr4} !== 2'b10)
         $display("FAIL restart_flags: got done=%b overrun=%b required done=1 overrun=0", done4, ovr4);
      else pass_cnt++;
      ack4 = 1'b1;
      step();
      ack4 = 1'b0;
   endtask

   task automatic test_overrun_back_to_back();
      st4 = 1'b1;
      step();
      st4 = 1'b0;
      send4(32'h0BADF00D);
      // chunk while holding, no ack
      dv4 = 1'b1; din4 = 4'h5;
      step();
      dv4 = 1'b0;
      chk_cnt++;
      if ({ovr4, done4} !== 2'b11)
         $display("FAIL overrun_set: got overrun=%b done=%b required overrun=1 done=1", ovr4, done4);
      else pass_cnt++;
      chk_cnt++;
      if (dout4 !== 32'h0BADF00D)
         $display("FAIL overrun_dout: got %h required %h", dout4, 32'h0BADF00D);
      else pass_cnt++;
      // start while holding, no ack: stays in HOLD
      st4 = 1'b1;
      step();
      st4 = 1'b0;
      chk_cnt++;
      if ({done4, busy4} !== 2'b10)
         $display("FAIL hold_start_ignored: got done=%b busy=%b required done=1 busy=0", done4, busy4);
      else pass_cnt++;
      // ack + start together
      ack4 = 1'b1; st4 = 1'b1;
      step();
      ack4 = 1'b0; st4 = 1'b0;
      chk_cnt++;
      if ({done4, busy4} !== 2'b01)
         $display("FAIL b2b_busy: got done=%b busy=%b required done=0 busy=1", done4, busy4);
      else pass_cnt++;
      send4(32'h00000001);
      chk_cnt++;
      if ({dout4, done4} !== {32'h00000001, 1'b1})
         $display("FAIL b2b_dout: got dout=%h done=%b required dout=00000001 done=1", dout4, done4);
      else pass_cnt++;
      chk_cnt++;
      if (ovr4 !== 1'b1)
         $display("FAIL overrun_sticky: got %b required 1", ovr4);
      else pass_cnt++;
      ack4 = 1'b1;
      step();
      ack4 = 1'b0;
   endtask

   task automatic test_reset_midframe();
      logic [31:0] w;
      w = 32'h12345678;
      st4 = 1'b1;
      step();
      st4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din4 = w[31-4*i -: 4];
         dv4  = 1'b1;
         step();
      end
      dv4 = 1'b0;
      reset = 1'b1;
      #1;
      chk_cnt++;
      if ({dout4, done4, busy4, ovr4, to4} !== 36'h0)
         $display("FAIL reset_async: got dout=%h done=%b busy=%b ovr=%b to=%b required all 0",
                  dout4, done4, busy4, ovr4, to4);
      else pass_cnt++;
      reset = 1'b0;
      step();
      st4 = 1'b1;
      step();
      st4 = 1'b0;
      send4(32'hA5A5A5A5);
      chk_cnt++;
      if ({dout4, done4} !== {32'hA5A5A5A5, 1'b1})
         $display("FAIL reset_recover: got dout=%h done=%b required dout=a5a5a5a5 done=1", dout4, done4);
      else pass_cnt++;
      ack4 = 1'b1;
      step();
      ack4 = 1'b0;
   endtask

   task automatic test_gaps_len8();
      logic [7:0] bytes_q [4];
      int         gaps [4];
      logic       to_seen;
      bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
      gaps    = '{1, 2, 1, 0};
      to_seen = 1'b0;
      st8 = 1'b1;
      step();
      st8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din8 = bytes_q[i];
         dv8  = 1'b1;
         step();
         to_seen = to_seen | to8;
         if (i == 2) begin
            chk_cnt++;
            if ({done8, busy8} !== 2'b01)
               $display("FAIL len8_midframe: got done=%b busy=%b required done=0 busy=1", done8, busy8);
            else pass_cnt++;
         end
         dv8 = 1'b0;
         for (int g = 0; g < gaps[i]; g++) begin
            din8 = 8'hEE;
            step();
            to_seen = to_seen | to8;
         end
      end
      chk_cnt++;
      if ({dout8, done8} !== {32'h12345678, 1'b1})
         $display("FAIL len8_dout: got dout=%h done=%b required dout=12345678 done=1", dout8, done8);
      else pass_cnt++;
      chk_cnt++;
      if (to_seen !== 1'b0)
         $display("FAIL len8_no_timeout: got timeoutErr seen=%b required 0", to_seen);
      else pass_cnt++;
      ack8 = 1'b1;
      step();
      ack8 = 1'b0;
   endtask

   task automatic test_timeout();
      st4 = 1'b1;
      step();
      st4 = 1'b0;
      din4 = 4'h3; dv4 = 1'b1;
      step();
      din4 = 4'h4;
      step();
      dv4 = 1'b0;
`ifdef SERIAL_RX_TIMEOUT_EN
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i < 16) begin
            chk_cnt++;
            if ({to4, busy4} !== 2'b01)
               $display("FAIL timeout_early_%0d: got to=%b busy=%b required to=0 busy=1", i, to4, busy4);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if ({to4, busy4, done4} !== 3'b100)
         $display("FAIL timeout_fire: got to=%b busy=%b done=%b required to=1 busy=0 done=0",
                  to4, busy4, done4);
      else pass_cnt++;
      chk_cnt++;
      if (dout4 !== 32'hA5A5A5A5)
         $display("FAIL timeout_dout: got %h required %h", dout4, 32'hA5A5A5A5);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (to4 !== 1'b0)
         $display("FAIL timeout_pulse_width: got %b required 0", to4);
      else pass_cnt++;
`else
      for (int i = 1; i <= 17; i++) begin
         step();
      end
      chk_cnt++;
      if ({to4, busy4} !== 2'b01)
         $display("FAIL no_timeout_wait: got to=%b busy=%b required to=0 busy=1", to4, busy4);
      else pass_cnt++;
      chk_cnt++;
      if (dout4 !== 32'hA5A5A5A5)
         $display("FAIL no_timeout_dout: got %h required %h", dout4, 32'hA5A5A5A5);
      else pass_cnt++;
`endif
   endtask

   initial begin
      chk_cnt  = 0;
      pass_cnt = 0;
      reset = 1'b1;
      din4 = '0; dv4 = 1'b0; st4 = 1'b0; ack4 = 1'b0;
      din8 = '0; dv8 = 1'b0; st8 = 1'b0; ack8 = 1'b0;
      test_reset();
      test_deadbeef();
      test_restart();
      test_overrun_back_to_back();
      test_reset_midframe();
      test_gaps_len8();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
